// File: rtl/ascon_aead_sequencer.sv
// Ascon-128 AEAD encryption sequencer: owns the 320-bit state, walks
// init / AD / plaintext / finalisation, and drives an external permutation.
module ascon_aead_sequencer #(
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic         ad_empty,
  input  logic         ad_valid,
  input  logic [63:0]  ad_data,
  input  logic         ad_last,
  output logic         ad_ready,
  input  logic         pt_valid,
  input  logic [63:0]  pt_data,
  input  logic         pt_last,
  output logic         pt_ready,
  output logic         ct_valid,
  output logic [63:0]  ct_data,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         busy,
  output logic         perm_start,
  output logic [4:0]   perm_rounds,
  output logic [319:0] perm_state,
  input  logic [319:0] perm_out,
  input  logic         perm_done
);

  typedef enum logic [2:0] {
    IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [319:0]   s_q, s_d;
  logic           perm_start_q, perm_start_d;
  logic           ad_empty_q, ad_empty_d;
  logic           ad_last_q, ad_last_d;
  logic           ct_valid_q, ct_valid_d;
  logic [63:0]    ct_data_q, ct_data_d;
  logic           tag_valid_q, tag_valid_d;
  logic [127:0]   tag_q, tag_d;
  logic           perm_fire;
  logic           in_perm;

  // A permutation completes only when perm_done is seen while our request is up.
  assign perm_fire = perm_start_q && perm_done;
  assign in_perm   = (state_q == INIT) || (state_q == AD_PERM) ||
                     (state_q == PT_PERM) || (state_q == FINAL);

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    ad_empty_d   = ad_empty_q;
    ad_last_d    = ad_last_q;
    ct_valid_d   = 1'b0;
    ct_data_d    = ct_data_q;
    tag_valid_d  = tag_valid_q;
    tag_d        = tag_q;
    perm_start_d = in_perm && !perm_fire;

    case (state_q)
      IDLE: begin
        if (start) begin
          s_d         = {IV, key, nonce};
          ad_empty_d  = ad_empty;
          tag_valid_d = 1'b0;
          state_d     = INIT;
        end
      end
      INIT: begin
        if (perm_fire) begin
          s_d = perm_out ^ {192'b0, key};
          if (ad_empty_q) begin
            s_d[0]  = ~s_d[0];
            state_d = PT_WAIT;
          end else begin
            state_d = AD_WAIT;
          end
        end
      end
      AD_WAIT: begin
        if (ad_valid) begin
          s_d[319:256] = s_q[319:256] ^ ad_data;
          ad_last_d    = ad_last;
          state_d      = AD_PERM;
        end
      end
      AD_PERM: begin
        if (perm_fire) begin
          s_d = perm_out;
          if (ad_last_q) begin
            s_d[0]  = ~s_d[0];
            state_d = PT_WAIT;
          end else begin
            state_d = AD_WAIT;
          end
        end
      end
      PT_WAIT: begin
        if (pt_valid) begin
          s_d[319:256] = s_q[319:256] ^ pt_data;
          ct_valid_d   = 1'b1;
          ct_data_d    = s_q[319:256] ^ pt_data;
          state_d      = pt_last ? FINAL : PT_PERM;
        end
      end
      PT_PERM: begin
        if (perm_fire) begin
          s_d     = perm_out;
          state_d = PT_WAIT;
        end
      end
      FINAL: begin
        // Entry cycle (request not yet raised) folds the key in before p12 sees S.
        if (!perm_start_q) begin
          s_d[255:128] = s_q[255:128] ^ key;
        end
        if (perm_fire) begin
          tag_d       = perm_out[127:0] ^ key;
          tag_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      s_q          <= '0;
      perm_start_q <= 1'b0;
      ad_empty_q   <= 1'b0;
      ad_last_q    <= 1'b0;
      ct_valid_q   <= 1'b0;
      ct_data_q    <= '0;
      tag_valid_q  <= 1'b0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      perm_start_q <= perm_start_d;
      ad_empty_q   <= ad_empty_d;
      ad_last_q    <= ad_last_d;
      ct_valid_q   <= ct_valid_d;
      ct_data_q    <= ct_data_d;
      tag_valid_q  <= tag_valid_d;
      tag_q        <= tag_d;
    end
  end

  assign ad_ready    = (state_q == AD_WAIT);
  assign pt_ready    = (state_q == PT_WAIT);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign ct_valid    = ct_valid_q;
  assign ct_data     = ct_data_q;
  assign tag_valid   = tag_valid_q;
  assign tag         = tag_q;
  assign perm_start  = perm_start_q;
  assign perm_state  = s_q;
  assign perm_rounds = !perm_start_q ? 5'd0 :
                       ((state_q == INIT) || (state_q == FINAL)) ? 5'd12 : 5'd6;

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Randomized bench for ascon_aead_sequencer with a permutation stub and a
// sponge-level reference model of the encryption flow.
module tb_ascon_aead_sequencer;

  localparam logic [63:0] IV = 64'h80400c0600000000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] nonce = '0;
  logic         ad_empty = 1'b0;
  logic         ad_valid = 1'b0;
  logic [63:0]  ad_data = '0;
  logic         ad_last = 1'b0;
  logic         ad_ready;
  logic         pt_valid = 1'b0;
  logic [63:0]  pt_data = '0;
  logic         pt_last = 1'b0;
  logic         pt_ready;
  logic         ct_valid;
  logic [63:0]  ct_data;
  logic         tag_valid;
  logic [127:0] tag;
  logic         busy;
  logic         perm_start;
  logic [4:0]   perm_rounds;
  logic [319:0] perm_state;
  logic [319:0] perm_out;
  logic         perm_done;

  ascon_aead_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
    .ad_empty(ad_empty), .ad_valid(ad_valid), .ad_data(ad_data),
    .ad_last(ad_last), .ad_ready(ad_ready), .pt_valid(pt_valid),
    .pt_data(pt_data), .pt_last(pt_last), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .tag_valid(tag_valid),
    .tag(tag), .busy(busy), .perm_start(perm_start),
    .perm_rounds(perm_rounds), .perm_state(perm_state),
    .perm_out(perm_out), .perm_done(perm_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stubMode = 0;
  int stubLat = 0;
  bit glitchEn = 1'b0;
  bit junkOn = 1'b0;
  int latCnt;

  logic [127:0] curKey, curNonce;
  bit           curAdEmpty;
  logic [63:0]  adBlocks[$];
  logic [63:0]  ptBlocks[$];
  logic [63:0]  expCt[$];
  int           expRounds[$];
  logic [127:0] expTag;
  logic [63:0]  gotCt[$];
  int           gotRounds[$];
  logic         lastStart = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Stub permutation: identity, or a cheap round-count-dependent scramble.
  function automatic logic [319:0] permModel(input logic [319:0] s, input int rounds);
    logic [319:0] r;
    if (stubMode == 0) return s;
    r = {s[312:0], s[319:313]};
    r[4:0]     = r[4:0] ^ 5'(rounds);
    r[319:315] = r[319:315] ^ 5'(rounds);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      perm_done <= 1'b0;
      perm_out  <= '0;
      latCnt    <= 0;
    end else begin
      perm_done <= 1'b0;
      if (perm_start && !perm_done) begin
        if (latCnt >= stubLat) begin
          perm_done <= 1'b1;
          perm_out  <= permModel(perm_state, int'(perm_rounds));
          latCnt    <= 0;
        end else begin
          latCnt <= latCnt + 1;
        end
      end else if (!perm_start && glitchEn && (!busy || ad_ready || pt_ready) &&
                   $urandom_range(0, 3) == 0) begin
        perm_done <= 1'b1;
        perm_out  <= {10{$urandom()}};
      end
    end
  end

  always @(negedge clk) begin
    if (perm_start && !lastStart) gotRounds.push_back(int'(perm_rounds));
    lastStart = perm_start;
    if (ct_valid) gotCt.push_back(ct_data);
  end

  // Reference: the sponge flow written directly over the whole state.
  task automatic computeExpected();
    logic [319:0] s;
    expCt.delete();
    expRounds.delete();
    s = {IV, curKey, curNonce};
    s = permModel(s, 12) ^ {192'b0, curKey};
    expRounds.push_back(12);
    if (curAdEmpty) s[0] = ~s[0];
    else begin
      for (int i = 0; i < adBlocks.size(); i++) begin
        s[319:256] = s[319:256] ^ adBlocks[i];
        s = permModel(s, 6);
        expRounds.push_back(6);
        if (i == adBlocks.size() - 1) s[0] = ~s[0];
      end
    end
    for (int i = 0; i < ptBlocks.size(); i++) begin
      s[319:256] = s[319:256] ^ ptBlocks[i];
      expCt.push_back(s[319:256]);
      if (i != ptBlocks.size() - 1) begin
        s = permModel(s, 6);
        expRounds.push_back(6);
      end
    end
    s[255:128] = s[255:128] ^ curKey;
    s = permModel(s, 12);
    expRounds.push_back(12);
    expTag = s[127:0] ^ curKey;
  endtask

  task automatic waitHandshake(input bit isPt, output bit ok);
    int cycles = 0;
    while (!(isPt ? pt_ready : ad_ready) && cycles < 300) begin
      if (junkOn) begin
        start = 1'($urandom_range(0, 1));
        if (!isPt) begin
          pt_valid = 1'($urandom_range(0, 1));
          pt_data  = {$urandom(), $urandom()};
        end
      end
      @(negedge clk);
      cycles++;
    end
    ok = (cycles < 300);
    if (ok) @(posedge clk);
    @(negedge clk);
    ad_valid = 1'b0;
    pt_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic startRun();
    gotCt.delete();
    gotRounds.delete();
    @(negedge clk);
    key = curKey; nonce = curNonce; ad_empty = curAdEmpty; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("tag_valid_cleared", tag_valid, 0);
    nonce    = {4{$urandom()}};
    ad_empty = ~ad_empty;
  endtask

  task automatic sendBlocks();
    bit ok;
    if (!curAdEmpty) begin
      for (int i = 0; i < adBlocks.size(); i++) begin
        ad_valid = 1'b1; ad_data = adBlocks[i]; ad_last = (i == adBlocks.size() - 1);
        waitHandshake(1'b0, ok);
        if (!ok) checkOutput("ad_handshake_timeout", 0, 1);
      end
    end
    for (int i = 0; i < ptBlocks.size(); i++) begin
      pt_valid = 1'b1; pt_data = ptBlocks[i]; pt_last = (i == ptBlocks.size() - 1);
      waitHandshake(1'b1, ok);
      if (!ok) checkOutput("pt_handshake_timeout", 0, 1);
    end
  endtask

  task automatic applyStimulus();
    int c = 0;
    computeExpected();
    startRun();
    sendBlocks();
    while (!tag_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    checkOutput("tag_valid_seen", tag_valid, 1);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("tag", tag, expTag);
    checkOutput("ct_count", gotCt.size(), expCt.size());
    for (int i = 0; i < expCt.size() && i < gotCt.size(); i++)
      checkOutput("ct_block", gotCt[i], expCt[i]);
    checkOutput("perm_count", gotRounds.size(), expRounds.size());
    for (int i = 0; i < expRounds.size() && i < gotRounds.size(); i++)
      checkOutput("perm_rounds", gotRounds[i], expRounds[i]);
    repeat (3) @(negedge clk);
    checkOutput("tag_hold", tag, expTag);
    checkOutput("tag_valid_hold", tag_valid, 1);
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_ad_ready"}, ad_ready, 0);
    checkOutput({pfx, "_pt_ready"}, pt_ready, 0);
    checkOutput({pfx, "_ct_valid"}, ct_valid, 0);
    checkOutput({pfx, "_ct_data"}, ct_data, 0);
    checkOutput({pfx, "_tag_valid"}, tag_valid, 0);
    checkOutput({pfx, "_tag"}, tag, 0);
    checkOutput({pfx, "_perm_start"}, perm_start, 0);
    checkOutput({pfx, "_perm_rounds"}, perm_rounds, 0);
    checkOutput({pfx, "_perm_state_zero"}, (perm_state == '0), 1);
  endtask

  task automatic setupBasic();
    stubMode = 0; stubLat = 0; glitchEn = 1'b0; junkOn = 1'b0;
    curKey = '0; curNonce = '0; curAdEmpty = 1'b1;
    adBlocks.delete(); ptBlocks.delete();
    ptBlocks.push_back(64'h0);
  endtask

  initial begin
    int nAd, nPt, c;
    bit ok;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;

    // Identity stub, empty AD, one zero block: known ciphertext and tag.
    setupBasic();
    applyStimulus();
    checkOutput("kat_ct", (gotCt.size() > 0) ? gotCt[0] : 64'hx, IV);
    checkOutput("kat_tag", tag, 128'h1);

    // One AD block plus two PT blocks: four invocations, two ciphertexts.
    setupBasic();
    curAdEmpty = 1'b0;
    adBlocks.push_back({$urandom(), $urandom()});
    ptBlocks.push_back({$urandom(), $urandom()});
    applyStimulus();
    checkOutput("four_perms", gotRounds.size(), 4);
    checkOutput("two_ct", gotCt.size(), 2);

    // Randomized runs with latency, spurious perm_done, start and pt_valid noise.
    for (int r = 0; r < 12; r++) begin
      stubMode = 1; stubLat = $urandom_range(0, 3); glitchEn = 1'b1; junkOn = 1'b1;
      curKey = {4{$urandom()}}; curNonce = {4{$urandom()}};
      nAd = $urandom_range(0, 3); nPt = $urandom_range(1, 3);
      curAdEmpty = (nAd == 0);
      adBlocks.delete(); ptBlocks.delete();
      for (int i = 0; i < nAd; i++) adBlocks.push_back({$urandom(), $urandom()});
      for (int i = 0; i < nPt; i++) ptBlocks.push_back({$urandom(), $urandom()});
      applyStimulus();
    end

    // Reset while the final permutation request is outstanding.
    stubMode = 1; stubLat = 3; glitchEn = 1'b0; junkOn = 1'b0;
    curKey = {4{$urandom()}}; curNonce = {4{$urandom()}}; curAdEmpty = 1'b1;
    adBlocks.delete(); ptBlocks.delete();
    ptBlocks.push_back({$urandom(), $urandom()});
    startRun();
    sendBlocks();
    c = 0;
    while (!perm_start && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("final_perm_seen", perm_start, 1);
    rst = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    setupBasic();
    applyStimulus();
    checkOutput("post_reset_ct", (gotCt.size() > 0) ? gotCt[0] : 64'hx, IV);
    checkOutput("post_reset_tag", tag, 128'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
